// File: rtl/mult_eval_pkg.sv
// Shared types and width helpers for the approximate-multiplier error evaluators.
package mult_eval_pkg;

  localparam int OP_W   = 4;
  localparam int PROD_W = 2 * OP_W;
  localparam int CNT_W  = 2 * OP_W + 1;
  localparam int SUM_W  = 4 * OP_W;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SWEEP = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } eval_state_t;

endpackage

// File: rtl/err_abs_diff.sv
// Unsigned |x - y| on N-bit operands, plus a flag for a nonzero difference.
module err_abs_diff
  import mult_eval_pkg::*;
#(
  parameter int N = PROD_W
) (
  input  logic [N-1:0] x,
  input  logic [N-1:0] y,
  output logic [N-1:0] mag,
  output logic         nz
);

  always_comb begin
    mag = (x >= y) ? (x - y) : (y - x);
    nz  = (x != y);
  end

endmodule

// File: rtl/mult4_err_eval.sv
// Exhaustive-sweep error evaluator for a 4x4 approximate multiplier.
// Optional first-failure capture is enabled by defining MULT_EVAL_FIRST_FAIL_EN.
//
// Host handshake: start is a request sampled every edge but accepted only in
// IDLE or DONE; busy is high from the accepting edge through the final compare,
// and done is a level that stays high until the next accepted start.
module mult4_err_eval
  import mult_eval_pkg::*;
#(
  parameter int W = OP_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic [W-1:0]      dut_a,
  output logic [W-1:0]      dut_b,
  input  logic [2*W-1:0]    dut_p,
  output logic [2*W:0]      err_count,
  output logic [2*W-1:0]    max_err,
  output logic [4*W-1:0]    sum_abs_err,
  output logic [W-1:0]      fail_a,
  output logic [W-1:0]      fail_b,
  output logic              fail_valid,
  output eval_state_t       dbg_state
);

  eval_state_t       state;
  logic [2*W-1:0]    cnt;
  logic              cmp_v;
  logic [2*W-1:0]    exact;
  logic [2*W-1:0]    diff;
  logic              diff_nz;
  logic              start_acc;
  logic              hit;

  assign start_acc = start && ((state == S_IDLE) || (state == S_DONE));
  assign exact     = {{W{1'b0}}, dut_a} * {{W{1'b0}}, dut_b};
  assign hit       = cmp_v && diff_nz;
  assign dbg_state = state;

  err_abs_diff #(.N(2*W)) u_abs (
    .x   (dut_p),
    .y   (exact),
    .mag (diff),
    .nz  (diff_nz)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_IDLE;
      busy        <= 1'b0;
      done        <= 1'b0;
      cnt         <= '0;
      cmp_v       <= 1'b0;
      dut_a       <= '0;
      dut_b       <= '0;
      err_count   <= '0;
      max_err     <= '0;
      sum_abs_err <= '0;
    end else begin
      // The compare stage trails the drive stage by one cycle, so the final
      // pair is still accumulated while the FSM sits in DRAIN.
      if (hit) begin
        err_count   <= err_count + {{2*W{1'b0}}, 1'b1};
        sum_abs_err <= sum_abs_err + {{2*W{1'b0}}, diff};
        if (diff > max_err) max_err <= diff;
      end
      cmp_v <= (state == S_SWEEP);

      case (state)
        S_IDLE, S_DONE: begin
          if (start_acc) begin
            state       <= S_SWEEP;
            busy        <= 1'b1;
            done        <= 1'b0;
            cnt         <= '0;
            err_count   <= '0;
            max_err     <= '0;
            sum_abs_err <= '0;
          end
        end
        S_SWEEP: begin
          {dut_a, dut_b} <= cnt;
          cnt            <= cnt + {{(2*W-1){1'b0}}, 1'b1};
          if (cnt == '1) state <= S_DRAIN;
        end
        S_DRAIN: begin
          state <= S_DONE;
          busy  <= 1'b0;
          done  <= 1'b1;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef MULT_EVAL_FIRST_FAIL_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fail_a     <= '0;
      fail_b     <= '0;
      fail_valid <= 1'b0;
    end else if (start_acc) begin
      fail_a     <= '0;
      fail_b     <= '0;
      fail_valid <= 1'b0;
    end else if (hit && !fail_valid) begin
      fail_a     <= dut_a;
      fail_b     <= dut_b;
      fail_valid <= 1'b1;
    end
  end
`else
  assign fail_a     = '0;
  assign fail_b     = '0;
  assign fail_valid = 1'b0;
`endif

endmodule

// File: tb/tb_mult4_err_eval.sv
// Directed bench for mult4_err_eval: exact, XOR-1 and stuck-at-0 multiplier models,
// reset mid-sweep, start spam while busy and restart from DONE.
module tb_mult4_err_eval;
  import mult_eval_pkg::*;

  localparam int W = 4;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           start = 1'b0;
  logic           busy, done;
  logic [W-1:0]   dut_a, dut_b;
  logic [2*W-1:0] dut_p;
  logic [2*W:0]   err_count;
  logic [2*W-1:0] max_err;
  logic [4*W-1:0] sum_abs_err;
  logic [W-1:0]   fail_a, fail_b;
  logic           fail_valid;
  eval_state_t    dbg_state;

  int total = 0;
  int bad   = 0;
  int mode  = 0;  // 0 exact, 1 exact xor 1, 2 stuck at 0

  always #5 clk = ~clk;

  mult4_err_eval #(.W(W)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .busy        (busy),
    .done        (done),
    .dut_a       (dut_a),
    .dut_b       (dut_b),
    .dut_p       (dut_p),
    .err_count   (err_count),
    .max_err     (max_err),
    .sum_abs_err (sum_abs_err),
    .fail_a      (fail_a),
    .fail_b      (fail_b),
    .fail_valid  (fail_valid),
    .dbg_state   (dbg_state)
  );

  // Behavioural multiplier models driving the product bus.
  always_comb begin
    dut_p = '0;
    case (mode)
      0: dut_p = {4'b0, dut_a} * {4'b0, dut_b};
      1: dut_p = ({4'b0, dut_a} * {4'b0, dut_b}) ^ 8'd1;
      default: dut_p = '0;
    endcase
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_results(input string tag, input int ec, input int me, input int sae,
                               input int fa, input int fb, input int fv);
    check({tag, "_err_count"}, 32'(err_count), 32'(ec));
    check({tag, "_max_err"}, 32'(max_err), 32'(me));
    check({tag, "_sum_abs_err"}, 32'(sum_abs_err), 32'(sae));
`ifdef MULT_EVAL_FIRST_FAIL_EN
    check({tag, "_fail_a"}, 32'(fail_a), 32'(fa));
    check({tag, "_fail_b"}, 32'(fail_b), 32'(fb));
    check({tag, "_fail_valid"}, 32'(fail_valid), 32'(fv));
`else
    check({tag, "_fail_a"}, 32'(fail_a), 32'd0);
    check({tag, "_fail_b"}, 32'(fail_b), 32'd0);
    check({tag, "_fail_valid"}, 32'(fail_valid), 32'd0);
`endif
  endtask

  // Called at a negedge; returns at the negedge where busy has dropped.
  task automatic sweep(input string tag, input bit spam, input bit chk_clear);
    int cyc;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    if (chk_clear) begin
      check({tag, "_clr_err_count"}, 32'(err_count), 32'd0);
      check({tag, "_clr_sum"}, 32'(sum_abs_err), 32'd0);
      check({tag, "_clr_max"}, 32'(max_err), 32'd0);
      check({tag, "_clr_done"}, 32'(done), 32'd0);
      check({tag, "_clr_fail_valid"}, 32'(fail_valid), 32'd0);
    end
    cyc = 0;
    while (busy && cyc < 1000) begin
      cyc++;
      if (spam) start = 1'($urandom_range(0, 1));
      @(negedge clk);
    end
    start = 1'b0;
    check({tag, "_busy_cycles"}, 32'(cyc), 32'd257);
    check({tag, "_done"}, 32'(done), 32'd1);
    check({tag, "_state"}, 32'(dbg_state), 32'(S_DONE));
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_state"}, 32'(dbg_state), 32'(S_IDLE));
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_done"}, 32'(done), 32'd0);
    check({tag, "_dut_a"}, 32'(dut_a), 32'd0);
    check({tag, "_dut_b"}, 32'(dut_b), 32'd0);
    check_results(tag, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    // Power-on reset
    repeat (3) @(negedge clk);
    check_reset_vals("por");
    rst = 1'b0;
    @(negedge clk);

    // Exact multiplier: no errors, first pair launched one cycle after start
    mode = 0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("first_busy", 32'(busy), 32'd1);
    @(negedge clk);
    check("first_pair_a", 32'(dut_a), 32'd0);
    check("first_pair_b", 32'(dut_b), 32'd0);
    @(negedge clk);
    check("second_pair_b", 32'(dut_b), 32'd1);
    repeat (300) @(negedge clk);
    check("exact_done", 32'(done), 32'd1);
    check_results("exact", 0, 0, 0, 0, 0, 0);

    // Exact xor 1: every pair off by one
    mode = 1;
    sweep("xor1", 1'b0, 1'b0);
    check_results("xor1", 256, 1, 256, 0, 0, 1);

    // Stuck at 0: error equals the exact product
    mode = 2;
    sweep("stuck0", 1'b0, 1'b0);
    check_results("stuck0", 225, 225, 14400, 1, 1, 1);

    // Restart from DONE clears on the start edge and re-accumulates identically
    sweep("restart", 1'b0, 1'b1);
    check_results("restart", 225, 225, 14400, 1, 1, 1);

    // Reset at sweep cycle 100
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (100) @(negedge clk);
    check("pre_rst_busy", 32'(busy), 32'd1);
    rst = 1'b1;
    #2;
    check_reset_vals("midrst");
    @(negedge clk);
    check_reset_vals("midrst_hold");
    rst = 1'b0;
    @(negedge clk);
    mode = 0;
    sweep("after_rst", 1'b0, 1'b0);
    check_results("after_rst", 0, 0, 0, 0, 0, 0);

    // Start spam while busy must not restart the sweep
    mode = 2;
    sweep("spam", 1'b1, 1'b0);
    check_results("spam", 225, 225, 14400, 1, 1, 1);
    repeat (3) @(negedge clk);
    check("spam_hold_done", 32'(done), 32'd1);
    check("spam_hold_count", 32'(err_count), 32'd225);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mult4_err_eval.md
# mult4_err_eval

Exhaustive-sweep error evaluator that sits directly downstream of the 4×4 approximate multiplier built from learned 2×2 cells. It drives every operand pair into the multiplier's A/B inputs, one pair per cycle, and captures the returned product P. It compares P against the exact product and accumulates mismatch count, maximum absolute error and summed absolute error. Results are reported to a host with a start/done handshake.

## Interface
- `W`, 4, operand width; multiplier product width is 2W; sweep length is 2^(2W) pairs.
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `start`  in  1  request a sweep; honoured only in IDLE or DONE.
- `busy`  out  1  high in SWEEP and DRAIN.
- `done`  out  1  level, high in DONE until the next accepted start.
- `dut_a`  out  W  operand A to the multiplier (registered).
- `dut_b`  out  W  operand B to the multiplier (registered).
- `dut_p`  in  2W  product returned combinationally by the multiplier.
- `err_count`  out  2W+1  number of pairs with P ≠ A·B.
- `max_err`  out  2W  largest |P − A·B| seen.
- `sum_abs_err`  out  4W  Σ|P − A·B| over the sweep.
- `fail_a`, `fail_b`  out  W each  operands of the first mismatching pair (see Configuration).
- `fail_valid`  out  1  `fail_a`/`fail_b` hold a captured pair.

## Operation
- FSM states are IDLE, SWEEP, DRAIN and DONE.
- Transitions:
  - IDLE or DONE with `start`=1 goes to SWEEP. On that edge, clear all result registers and `fail_valid`, and load the pair counter to 0.
  - In SWEEP, the pair counter (2W bits) drives {`dut_a`,`dut_b`} = {cnt[2W-1:W], cnt[W-1:0]}, so B is the fast index. The counter increments each cycle.
  - When the counter wraps from all-ones to 0, go to DRAIN. The last pair is still being compared.
  - DRAIN goes to DONE after one cycle.
- Comparison pipeline:
  - A one-stage valid flag `cmp_v` follows each driven pair by one cycle.
  - When `cmp_v`=1, compute `exact` = `dut_a`·`dut_b` (2W bits, unsigned) from the registered operands currently on the bus, and `diff` = |`dut_p` − `exact|` (2W bits, unsigned magnitude).
  - Operands are held stable for that compare cycle, so the compare sees the pair launched in the previous cycle.
- Accumulation, applied when `cmp_v`=1 and `diff`≠0:
  - `err_count` += 1.
  - `sum_abs_err` += `diff`.
  - `max_err` = max(`max_err`, `diff`).
- No saturation is needed: widths are sized for the worst case, 2^(2W)·(2^(2W)−1) < 2^(4W).
- `start` while `busy` is ignored and has no side effects.
- `start` in DONE restarts the sweep and clears results on the same edge.
- Results remain stable and readable in DONE and IDLE.

## Timing
- Reset values:
  - State is IDLE.
  - `busy`=0, `done`=0.
  - `dut_a`=0, `dut_b`=0.
  - `err_count`, `max_err`, `sum_abs_err`, `fail_a`, `fail_b` = 0.
  - `fail_valid`=0, `cmp_v`=0.
- Start to first compare is 2 cycles: the start edge, then the first pair is driven, then it is compared.
- `busy` is high for exactly 2^(2W)+1 cycles, i.e. 257 for W=4.
- `done` rises on the edge after the last compare.
- Reset mid-sweep: asynchronous return to IDLE with all outputs at reset values. Partial results are discarded.
- Simultaneous `start` and last-compare edge: `start` is ignored because the block is busy.
- `dut_p` must settle within one cycle of `dut_a`/`dut_b` changing. The multiplier is combinational.

## Configuration
- `MULT_EVAL_FIRST_FAIL_EN` defined:
  - On the first compare with `diff`≠0 while `fail_valid`=0, latch `fail_a`/`fail_b` from the operand bus and set `fail_valid`.
  - The latched values are held until the next accepted start or reset.
- Not defined:
  - The capture logic is absent.
  - `fail_a`, `fail_b` and `fail_valid` are tied to 0.
  - Ports remain present so the port list is unchanged.

## Structure
- Shared package `mult_eval_pkg` holds:
  - the state enum type (IDLE/SWEEP/DRAIN/DONE);
  - width helper constants for product (2W), count (2W+1) and sum (4W).
- One sub-module, `err_abs_diff`: combinational unsigned |x − y| on 2W-bit operands plus a nonzero flag. It is reused by any later evaluator variant.

## Test plan
- Exact behavioural multiplier on `dut_p`, pulse `start` → `busy` high for 257 cycles, then `done`=1. Expect `err_count`=0, `max_err`=0, `sum_abs_err`=0, `fail_valid`=0.
- `dut_p` = exact XOR 1 → `err_count`=256, `max_err`=1, `sum_abs_err`=256. With the macro: `fail_a`=0, `fail_b`=0, `fail_valid`=1.
- `dut_p` stuck at 0 → `err_count`=225, `max_err`=225, `sum_abs_err`=14400. With the macro: `fail_a`=1, `fail_b`=1.
- Assert `rst` at sweep cycle 100, release, then start again with the exact model → all outputs read their reset values during reset; the final results are all zero and `done` comes 257 cycles after the new start.
- Pulse `start` repeatedly while `busy` → no restart; `done` timing is unchanged.
- `start` while in DONE with the stuck-at-0 model → results clear on the start edge and re-accumulate to the same values.
